// File: rtl/merge_n.sv
// N-input select-driven merge feeding a small output FIFO.
// Optional burst selects are compiled in with MERGE_N_BURST_EN.
module merge_n #(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 4,
    parameter int OUT_DEPTH = 2,
    parameter int BURST_W   = 4,
    localparam int SEL_W    = $clog2(NUM_IN),
`ifdef MERGE_N_BURST_EN
    localparam int TOK_W    = SEL_W + BURST_W
`else
    localparam int TOK_W    = SEL_W
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [TOK_W-1:0]        sel_data,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sel
);

    localparam int AW = $clog2(OUT_DEPTH);

    typedef enum logic {S_SEL, S_DATA} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem [OUT_DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      occ_q;
    logic             fifo_full, push, pop;
    logic [SEL_W-1:0] tok_idx;
    logic             tok_ok;
    logic             last_beat;

    assign tok_idx = sel_data[SEL_W-1:0];
    assign tok_ok  = 32'(tok_idx) < NUM_IN;

`ifdef MERGE_N_BURST_EN
    logic [BURST_W:0] cnt_q, cnt_d;
    assign last_beat = cnt_q == (BURST_W+1)'(1);
`else
    assign last_beat = 1'b1;
`endif

    // Full/empty come from registered occupancy only: no out_ready -> in_ready path.
    assign fifo_full = occ_q == (AW+1)'(OUT_DEPTH);
    assign out_valid = occ_q != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rp_q] : '0;
    assign err_sel   = err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
        sel_ready = 1'b0;
        in_ready  = '0;
        push      = 1'b0;
`ifdef MERGE_N_BURST_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_SEL: begin
                sel_ready = !rst;
                if (sel_valid && !rst) begin
                    if (tok_ok) begin
                        state_d = S_DATA;
                        idx_d   = tok_idx;
`ifdef MERGE_N_BURST_EN
                        cnt_d = {1'b0, sel_data[TOK_W-1:SEL_W]}
                              + (BURST_W+1)'(1);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                in_ready[idx_q] = !fifo_full && !rst;
                push = in_valid[idx_q] && in_ready[idx_q];
                if (push) begin
                    if (last_beat) state_d = S_SEL;
`ifdef MERGE_N_BURST_EN
                    cnt_d = cnt_q - (BURST_W+1)'(1);
`endif
                end
            end
            default: state_d = S_SEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SEL;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
`ifdef MERGE_N_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef MERGE_N_BURST_EN
            cnt_q   <= cnt_d;
`endif
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= in_data[int'(idx_q)*WIDTH +: WIDTH];
    end

endmodule

// File: tb/tb_merge_n.sv
// Scoreboard bench for merge_n: expected packets queued at select issue,
// popped by a monitor on every output handshake.
module tb_merge_n;
    localparam int W    = 8;
    localparam int NI   = 3;
    localparam int DEP  = 2;
    localparam int BW   = 4;
    localparam int SELW = $clog2(NI);
`ifdef MERGE_N_BURST_EN
    localparam int TW   = SELW + BW;
    localparam int MAXB = 3;
`else
    localparam int TW   = SELW;
    localparam int MAXB = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI*W-1:0] in_data = '0;
    logic [NI-1:0]   in_valid = '0;
    logic [NI-1:0]   in_ready;
    logic [TW-1:0]   sel_data = '0;
    logic            sel_valid = 1'b0;
    logic            sel_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            err_sel;

    int              n_chk = 0;
    int              n_fail = 0;
    logic [W-1:0]    exp_q[$];
    bit              stop_rnd = 1'b0;

    merge_n #(.WIDTH(W), .NUM_IN(NI), .OUT_DEPTH(DEP), .BURST_W(BW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel_data(sel_data), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_onehot", 32'($countones(in_ready) <= 1), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_output", 0, 1);
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_junk(input int keep);
        for (int p = 0; p < NI; p++) begin
            if (p != keep) begin
                in_data[p*W +: W] = W'($urandom);
                in_valid[p] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic send_token(input int idx, input int burst,
                              input bit rnd, input logic [W-1:0] d0);
        logic [W-1:0] pk[$];
        int t;
        int k;
        bit done;
        for (int j = 0; idx < NI && j <= burst; j++) begin
            logic [W-1:0] v;
            v = rnd ? W'($urandom) : d0 + W'(j);
            pk.push_back(v);
            exp_q.push_back(v);
        end
        @(posedge clk); #1;
        sel_data  = TW'(idx) | (TW'(burst) << SELW);
        sel_valid = 1'b1;
        drive_junk(-1);
        t = 0;
        @(negedge clk);
        while (!sel_ready && t < 300) begin
            @(posedge clk); #1 drive_junk(-1);
            @(negedge clk);
            t++;
        end
        chk("sel_handshake", 32'(sel_ready), 1);
        @(posedge clk); #1;
        sel_valid = 1'b0;
        sel_data  = '0;
        if (idx >= NI) begin
            @(negedge clk);
            chk("err_pulse", 32'(err_sel), 1);
            chk("err_no_in_ready", 32'(in_ready), 0);
            chk("err_stay_sel", 32'(sel_ready), 1);
            @(negedge clk);
            chk("err_one_cycle", 32'(err_sel), 0);
            return;
        end
        k = 0;
        t = 0;
        done = 1'b0;
        drive_junk(idx);
        in_data[idx*W +: W] = pk[0];
        in_valid[idx] = 1'b1;
        @(negedge clk);
        while (!done) begin
            if (in_ready[idx]) begin
                @(posedge clk); #1;
                k++;
                t = 0;
                drive_junk(idx);
                if (k < pk.size()) in_data[idx*W +: W] = pk[k];
                in_valid[idx] = k < pk.size();
                @(negedge clk);
                chk("latency_out_valid", 32'(out_valid), 1);
                if (k == pk.size()) begin
                    chk("sel_ready_back", 32'(sel_ready), 1);
                    done = 1'b1;
                end
            end else if (t >= 300) begin
                chk("in_handshake_timeout", 32'(in_ready[idx]), 1);
                in_valid[idx] = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clk); #1 drive_junk(idx);
                @(negedge clk);
                t++;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_sel_ready", 32'(sel_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_err_sel", 32'(err_sel), 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("sel_ready_after_rst", 32'(sel_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(out_valid), 0);
        end

        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) send_token(i, 0, 1'b0, W'(32'h10 + i));
        drain();

        send_token(3, 0, 1'b0, '0);
        send_token(1, 0, 1'b0, 8'h31);
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int j = 0; j < 4; j++) send_token(2, 0, 1'b0, W'(32'h20 + j));
            end
        join_none
        repeat (12) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_head", 32'(out_data), 32'h20);
        @(posedge clk); #1 out_ready = 1'b1;
        wait fork;
        drain();

`ifdef MERGE_N_BURST_EN
        send_token(1, 3, 1'b0, 8'hA0);
        drain();
`endif

        out_ready = 1'b0;
        send_token(1, 0, 1'b1, '0);
        in_valid = '0;
        @(posedge clk); #1;
        sel_data  = TW'(2);
        sel_valid = 1'b1;
        @(negedge clk);
        chk("mid_sel_ready", 32'(sel_ready), 1);
        @(posedge clk); #1;
        sel_valid = 1'b0;
        sel_data  = '0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_sel_ready", 32'(sel_ready), 1);
        out_ready = 1'b1;
        send_token(0, 0, 1'b0, 8'h77);
        drain();

        fork
            begin
                while (!stop_rnd) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int n = 0; n < 40; n++) begin
            send_token(int'($urandom_range(0, NI)),
                       int'($urandom_range(0, MAXB)), 1'b1, '0);
        end
        stop_rnd = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("final_out_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
